count_uart_tx: RTL and testbench

//  Downstream consumer of the 8-bit up-counter output (uo_out). On a trigger it snapshots the

---
 rtl/counter_pkg.sv | 19 +
 rtl/baud_tick_gen.sv | 28 ++
 rtl/count_uart_tx.sv | 117 +++++++++++
 tb/tb_count_uart_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - constants and state encoding shared by the counter core and its UART tap
package counter_pkg;

   localparam int CNT_W           = 8;
   localparam int UART_FRAME_BITS = 10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP
   } uart_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-period timer; tick marks the last enabled cycle of each UART bit
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (ena) begin
         if (clr || cnt == LAST) cnt <= '0;
         else                    cnt <= cnt + 1'b1;
      end
   end

   assign tick = ena && !clr && (cnt == LAST);

endmodule

// File: rtl/count_uart_tx.sv
// rtl/count_uart_tx.sv - snapshots the counter value on trig and sends it as one UART 8N1 frame
module count_uart_tx
   import counter_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [DATA_W-1:0] count_in,
   input  logic              trig,
   input  logic              clr_ovr,
   output logic              tx,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

   uart_state_t       state, state_d;
   logic [DATA_W-1:0] shreg, shreg_d;
   logic [IW-1:0]     bit_idx, bit_idx_d;
   logic              tx_d, busy_d, done_d, ovr_d;
   logic              tick;
   logic              baud_clr;

   // Holding the baud counter clear while idle aligns bit periods to the capture edge.
   assign baud_clr = (state == IDLE);

   baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .clr   (baud_clr),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d   = state;
      shreg_d   = shreg;
      bit_idx_d = bit_idx;
      tx_d      = tx;
      busy_d    = busy;
      ovr_d     = overrun;
      // done is a strict one-cycle pulse, so it drops even when ena freezes everything else.
      done_d    = 1'b0;
      if (ena) begin
         if (trig && state != IDLE) ovr_d = 1'b1;
         else if (clr_ovr)          ovr_d = 1'b0;
         case (state)
            IDLE: begin
               if (trig) begin
                  state_d   = START;
                  shreg_d   = count_in;
                  bit_idx_d = '0;
                  tx_d      = 1'b0;
                  busy_d    = 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
                  tx_d      = shreg[0];
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx == LAST_BIT) begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end else begin
                     bit_idx_d = bit_idx + 1'b1;
                     shreg_d   = shreg >> 1;
                     tx_d      = shreg[1];
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         shreg   <= shreg_d;
         bit_idx <= bit_idx_d;
         tx      <= tx_d;
         busy    <= busy_d;
         done    <= done_d;
         overrun <= ovr_d;
      end
   end

endmodule

// File: tb/tb_count_uart_tx.sv
// tb/tb_count_uart_tx.sv - directed self-checking bench for count_uart_tx with CLKS_PER_BIT=4
module tb_count_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       trig = 1'b0;
   logic       clr_ovr = 1'b0;
   logic [7:0] count_in = 8'h00;
   logic       tx, busy, done, overrun;
   logic       ov0, ov1;

   int n_cmp = 0;
   int n_err = 0;

   count_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .count_in (count_in),
      .trig     (trig),
      .clr_ovr  (clr_ovr),
      .tx       (tx),
      .busy     (busy),
      .done     (done),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] expand(input logic [9:0] p);
      logic [39:0] e;
      for (int k = 0; k < 40; k++) e[k] = p[k/4];
      return e;
   endfunction

   // Called with trig/count_in already set up in IDLE; the first cyc is the capture edge.
   // mode: 0 drop trig, 1 hold trig, 2 pulse trig only while ena is off, 3 step count_in.
   task automatic frame(input string tag, input logic [9:0] pat, input int mode,
                        input int off_at, input int off_len, input int exp_busy,
                        output logic o0, output logic o1);
      logic [39:0] txv = '0;
      int   idx = 0, nbusy = 0, ndone = 0, nfrz = 0, c = 0;
      logic last_tx = 1'b1, prev_ena = 1'b1;
      o0 = 1'bx;
      o1 = 1'bx;
      cyc();
      if (mode != 1) trig = 1'b0;
      if (mode == 3) count_in++;
      while (busy === 1'b1 && c < 120) begin
         ena = !(c >= off_at && c < off_at + off_len);
         if (mode == 2) trig = !ena && (c % 2 == 0);
         if (c == 0) o0 = overrun;
         if (c == 1) o1 = overrun;
         if (!prev_ena && tx !== last_tx) nfrz++;
         if (ena && idx < 40) begin
            txv[idx] = tx;
            idx++;
         end
         last_tx  = tx;
         prev_ena = ena;
         nbusy++;
         cyc();
         if (mode == 3) count_in++;
         if (done === 1'b1) ndone++;
         c++;
      end
      ena = 1'b1;
      if (mode != 1) trig = 1'b0;
      chk({tag, ".bits"},   txv,   expand(pat));
      chk({tag, ".busy"},   nbusy, exp_busy);
      chk({tag, ".done"},   ndone, 1);
      chk({tag, ".frozen"}, nfrz,  0);
      chk({tag, ".txidle"}, tx,    1'b1);
   endtask

   initial begin
      // 1: reset values, then 50 idle cycles
      cyc();
      cyc();
      chk("rst.tx", tx, 1'b1);
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      chk("rst.ovr", overrun, 1'b0);
      rst_n = 1'b1;
      begin
         int bad = 0;
         for (int i = 0; i < 50; i++) begin
            cyc();
            if ({tx, busy, done, overrun} !== 4'b1000) bad++;
         end
         chk("idle50", bad, 0);
      end

      // 2: 0x2B -> 0,1,1,0,1,0,1,0,0,1
      count_in = 8'h2B;
      trig = 1'b1;
      frame("f2B", 10'b1001010110, 0, 999, 0, 40, ov0, ov1);
      cyc();
      chk("f2B.donefall", done, 1'b0);

      // 3: running counter, capture at 0x10
      count_in = 8'h00;
      while (count_in != 8'h10) begin
         cyc();
         count_in++;
      end
      trig = 1'b1;
      frame("snap", {1'b1, 8'h10, 1'b0}, 3, 999, 0, 40, ov0, ov1);
      chk("snap.ovr", overrun, 1'b0);
      cyc();

      // 4: trig held high -> back-to-back frames and overrun
      count_in = 8'h3C;
      trig = 1'b1;
      frame("b2b1", {1'b1, 8'h3C, 1'b0}, 1, 999, 0, 40, ov0, ov1);
      chk("b2b1.ov0", ov0, 1'b0);
      chk("b2b1.ov1", ov1, 1'b1);
      frame("b2b2", {1'b1, 8'h3C, 1'b0}, 1, 999, 0, 40, ov0, ov1);
      chk("b2b2.ov0", ov0, 1'b1);
      cyc();
      chk("b2b3.busy", busy, 1'b1);
      clr_ovr = 1'b1;
      cyc();
      chk("clr_vs_set", overrun, 1'b1);
      trig = 1'b0;
      cyc();
      chk("clr_only", overrun, 1'b0);
      clr_ovr = 1'b0;
      begin
         int w = 0;
         while (busy === 1'b1 && w < 60) begin
            cyc();
            w++;
         end
         chk("b2b3.end", busy, 1'b0);
      end
      cyc();

      // 5: ena dropped for 10 cycles mid-DATA, trig pulses ignored
      count_in = 8'hA5;
      trig = 1'b1;
      frame("ena", {1'b1, 8'hA5, 1'b0}, 2, 14, 10, 50, ov0, ov1);
      chk("ena.ovr", overrun, 1'b0);
      cyc();

      // 6: reset in data bit 3, then a clean 0xFF frame
      count_in = 8'h5A;
      trig = 1'b1;
      cyc();
      trig = 1'b0;
      repeat (18) cyc();
      chk("mid.busy_pre", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid.tx", tx, 1'b1);
      chk("mid.busy", busy, 1'b0);
      chk("mid.done", done, 1'b0);
      cyc();
      cyc();
      rst_n = 1'b1;
      begin
         int bad = 0;
         for (int i = 0; i < 5; i++) begin
            cyc();
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad++;
         end
         chk("mid.quiet", bad, 0);
      end
      count_in = 8'hFF;
      trig = 1'b1;
      frame("fFF", {1'b1, 8'hFF, 1'b0}, 0, 999, 0, 40, ov0, ov1);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
